// File: rtl/l2cache_req_arb.sv
// Request arbiter in front of the L2 request buffer: picks one of five sources
// (op > round-robin I/Dr/Dw > prefetch), registers its fields and holds until L2 completes.
module l2cache_req_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    output logic        i_ack,
    input  logic        dr_req,
    input  logic [31:0] dr_addr,
    input  logic [1:0]  dr_size,
    input  logic        dr_SUC,
    output logic        dr_ack,
    input  logic        dw_req,
    input  logic [31:0] dw_addr,
    input  logic [31:0] dw_data,
    input  logic [3:0]  dw_wstrb,
    input  logic [1:0]  dw_size,
    input  logic        dw_SUC,
    output logic        dw_ack,
    input  logic        op_req,
    input  logic [31:0] op_code,
    input  logic [31:0] op_addr,
    output logic        op_ack,
    input  logic        pf_req,
    input  logic [31:0] pf_addr,
    input  logic        pf_type,
    output logic        pf_ack,
    input  logic        l2_ready,
    input  logic        l2_done,
    output logic        rbuf_we,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic [31:0] out_opcode,
    output logic [31:0] out_opaddr,
    output logic        out_opflag,
    output logic        out_SUC,
    output logic        out_prefetch,
    output logic        out_pref_type,
    output logic [3:0]  out_wstrb,
    output logic [1:0]  out_from,
    output logic [1:0]  out_size
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned FROM_W = 2;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned RR_W   = 2;
    localparam int unsigned NSRC   = 5;

    localparam logic [RR_W-1:0]   RR_I  = 2'd0;
    localparam logic [RR_W-1:0]   RR_DR = 2'd1;
    localparam logic [RR_W-1:0]   RR_DW = 2'd2;

    localparam logic [FROM_W-1:0] FROM_NONE = 2'd0;
    localparam logic [FROM_W-1:0] FROM_I    = 2'd1;
    localparam logic [FROM_W-1:0] FROM_DR   = 2'd2;
    localparam logic [FROM_W-1:0] FROM_DW   = 2'd3;

    // ack bit positions; the I/Dr/Dw positions equal their round-robin index
    localparam int unsigned ACK_OP = 3;
    localparam int unsigned ACK_PF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] opcode;
        logic [ADDR_W-1:0] opaddr;
        logic              opflag;
        logic              suc;
        logic              prefetch;
        logic              pref_type;
        logic [STRB_W-1:0] wstrb;
        logic [FROM_W-1:0] from;
        logic [SIZE_W-1:0] size;
    } req_fields_t;

    state_t            state_q, state_d;
    logic              done_pend_q, done_pend_d;
    logic [RR_W-1:0]   rr_q, rr_d;
    req_fields_t       fld_q, fld_d, win_fld;
    logic              we_q, we_d;
    logic [NSRC-1:0]   ack_q, ack_d;
    logic              rr_hit;
    logic [RR_W-1:0]   rr_win;

    // Round-robin search among I/Dr/Dw starting after the last granted one
    always_comb begin
        rr_hit = 1'b0;
        rr_win = RR_I;
        case (rr_q)
            RR_I: begin
                if (dr_req)      begin rr_hit = 1'b1; rr_win = RR_DR; end
                else if (dw_req) begin rr_hit = 1'b1; rr_win = RR_DW; end
                else if (i_req)  begin rr_hit = 1'b1; rr_win = RR_I;  end
            end
            RR_DR: begin
                if (dw_req)      begin rr_hit = 1'b1; rr_win = RR_DW; end
                else if (i_req)  begin rr_hit = 1'b1; rr_win = RR_I;  end
                else if (dr_req) begin rr_hit = 1'b1; rr_win = RR_DR; end
            end
            default: begin
                if (i_req)       begin rr_hit = 1'b1; rr_win = RR_I;  end
                else if (dr_req) begin rr_hit = 1'b1; rr_win = RR_DR; end
                else if (dw_req) begin rr_hit = 1'b1; rr_win = RR_DW; end
            end
        endcase
    end

    // Field bundle of the would-be winner; unused fields stay zero
    always_comb begin
        win_fld = '0;
        if (op_req) begin
            win_fld.opcode = op_code;
            win_fld.opaddr = op_addr;
            win_fld.opflag = 1'b1;
            win_fld.from   = FROM_NONE;
        end else if (rr_hit) begin
            case (rr_win)
                RR_I: begin
                    win_fld.addr = i_addr;
                    win_fld.size = i_size;
                    win_fld.from = FROM_I;
                end
                RR_DR: begin
                    win_fld.addr = dr_addr;
                    win_fld.size = dr_size;
                    win_fld.suc  = dr_SUC;
                    win_fld.from = FROM_DR;
                end
                default: begin
                    win_fld.addr  = dw_addr;
                    win_fld.data  = dw_data;
                    win_fld.wstrb = dw_wstrb;
                    win_fld.size  = dw_size;
                    win_fld.suc   = dw_SUC;
                    win_fld.from  = FROM_DW;
                end
            endcase
        end else begin
            win_fld.addr      = pf_addr;
            win_fld.prefetch  = 1'b1;
            win_fld.pref_type = pf_type;
            win_fld.from      = FROM_NONE;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        done_pend_d = done_pend_q;
        rr_d        = rr_q;
        fld_d       = fld_q;
        we_d        = 1'b0;
        ack_d       = '0;
        case (state_q)
            ST_IDLE: begin
                if (l2_ready && (op_req || rr_hit || pf_req)) begin
                    state_d = ST_GRANT;
                    we_d    = 1'b1;
                    fld_d   = win_fld;
                    if (op_req) begin
                        ack_d[ACK_OP] = 1'b1;
                    end else if (rr_hit) begin
                        ack_d[rr_win] = 1'b1;
                        rr_d          = rr_win;
                    end else begin
                        ack_d[ACK_PF] = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                state_d = ST_BUSY;
                if (l2_done) begin
                    done_pend_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (l2_done || done_pend_q) begin
                    state_d     = ST_IDLE;
                    done_pend_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                done_pend_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            done_pend_q <= 1'b0;
            rr_q        <= RR_DW;
            fld_q       <= '0;
            we_q        <= 1'b0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            done_pend_q <= done_pend_d;
            rr_q        <= rr_d;
            fld_q       <= fld_d;
            we_q        <= we_d;
            ack_q       <= ack_d;
        end
    end

    assign rbuf_we       = we_q;
    assign i_ack         = ack_q[0];
    assign dr_ack        = ack_q[1];
    assign dw_ack        = ack_q[2];
    assign op_ack        = ack_q[ACK_OP];
    assign pf_ack        = ack_q[ACK_PF];
    assign out_addr      = fld_q.addr;
    assign out_data      = fld_q.data;
    assign out_opcode    = fld_q.opcode;
    assign out_opaddr    = fld_q.opaddr;
    assign out_opflag    = fld_q.opflag;
    assign out_SUC       = fld_q.suc;
    assign out_prefetch  = fld_q.prefetch;
    assign out_pref_type = fld_q.pref_type;
    assign out_wstrb     = fld_q.wstrb;
    assign out_from      = fld_q.from;
    assign out_size      = fld_q.size;

endmodule

// File: tb/tb_l2cache_req_arb.sv
// Bench for l2cache_req_arb: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_l2cache_req_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0, dr_req = 1'b0, dw_req = 1'b0, op_req = 1'b0, pf_req = 1'b0;
    logic [31:0] i_addr = '0, dr_addr = '0, dw_addr = '0, dw_data = '0;
    logic [31:0] op_code = '0, op_addr = '0, pf_addr = '0;
    logic [1:0]  i_size = '0, dr_size = '0, dw_size = '0;
    logic        dr_SUC = 1'b0, dw_SUC = 1'b0, pf_type = 1'b0;
    logic [3:0]  dw_wstrb = '0;
    logic        l2_ready = 1'b0, l2_done = 1'b0;
    logic        i_ack, dr_ack, dw_ack, op_ack, pf_ack, rbuf_we;
    logic [31:0] out_addr, out_data, out_opcode, out_opaddr;
    logic        out_opflag, out_SUC, out_prefetch, out_pref_type;
    logic [3:0]  out_wstrb;
    logic [1:0]  out_from, out_size;

    l2cache_req_arb dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_size(i_size), .i_ack(i_ack),
        .dr_req(dr_req), .dr_addr(dr_addr), .dr_size(dr_size), .dr_SUC(dr_SUC), .dr_ack(dr_ack),
        .dw_req(dw_req), .dw_addr(dw_addr), .dw_data(dw_data), .dw_wstrb(dw_wstrb),
        .dw_size(dw_size), .dw_SUC(dw_SUC), .dw_ack(dw_ack),
        .op_req(op_req), .op_code(op_code), .op_addr(op_addr), .op_ack(op_ack),
        .pf_req(pf_req), .pf_addr(pf_addr), .pf_type(pf_type), .pf_ack(pf_ack),
        .l2_ready(l2_ready), .l2_done(l2_done), .rbuf_we(rbuf_we),
        .out_addr(out_addr), .out_data(out_data), .out_opcode(out_opcode), .out_opaddr(out_opaddr),
        .out_opflag(out_opflag), .out_SUC(out_SUC), .out_prefetch(out_prefetch),
        .out_pref_type(out_pref_type), .out_wstrb(out_wstrb), .out_from(out_from), .out_size(out_size)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: transaction bookkeeping plus expected outputs
    bit          m_wait, m_early, hold_mode;
    int          m_gedge, m_last, edge_n;
    logic        e_we;
    logic [4:0]  e_ack;   // [0]=I [1]=Dr [2]=Dw [3]=op [4]=pf
    logic [31:0] e_addr, e_data, e_opcode, e_opaddr;
    logic        e_opflag, e_suc, e_pf, e_pt;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_from, e_size;

    task automatic clear_fields();
        e_addr = '0; e_data = '0; e_opcode = '0; e_opaddr = '0;
        e_opflag = 1'b0; e_suc = 1'b0; e_pf = 1'b0; e_pt = 1'b0;
        e_wstrb = '0; e_from = '0; e_size = '0;
    endtask

    task automatic model_reset();
        m_wait = 1'b0; m_early = 1'b0; m_last = 2;
        e_we = 1'b0; e_ack = '0;
        clear_fields();
    endtask

    // One clock edge: a grant occupies the next cycle, then completion is awaited
    task automatic model_step();
        bit rr_req[3];
        int pick;
        rr_req[0] = i_req; rr_req[1] = dr_req; rr_req[2] = dw_req;
        e_we = 1'b0; e_ack = '0;
        if (m_wait) begin
            if (edge_n == m_gedge + 1) m_early = l2_done;
            else if (m_early || l2_done) m_wait = 1'b0;
        end else if (l2_ready && (op_req || i_req || dr_req || dw_req || pf_req)) begin
            pick = -1;
            if (!op_req)
                for (int k = 1; k <= 3; k++)
                    if (pick < 0 && rr_req[(m_last + k) % 3]) pick = (m_last + k) % 3;
            clear_fields();
            e_we = 1'b1; m_wait = 1'b1; m_early = 1'b0; m_gedge = edge_n;
            if (op_req) begin
                e_ack[3] = 1'b1; e_opcode = op_code; e_opaddr = op_addr; e_opflag = 1'b1;
            end else if (pick == 0) begin
                e_ack[0] = 1'b1; e_addr = i_addr; e_size = i_size; e_from = 2'd1; m_last = 0;
            end else if (pick == 1) begin
                e_ack[1] = 1'b1; e_addr = dr_addr; e_size = dr_size; e_suc = dr_SUC;
                e_from = 2'd2; m_last = 1;
            end else if (pick == 2) begin
                e_ack[2] = 1'b1; e_addr = dw_addr; e_data = dw_data; e_wstrb = dw_wstrb;
                e_size = dw_size; e_suc = dw_SUC; e_from = 2'd3; m_last = 2;
            end else begin
                e_ack[4] = 1'b1; e_addr = pf_addr; e_pf = 1'b1; e_pt = pf_type;
            end
        end
        edge_n++;
    endtask

    task automatic compare_all();
        check_val("rbuf_we", 32'(rbuf_we), 32'(e_we));
        check_val("i_ack", 32'(i_ack), 32'(e_ack[0]));
        check_val("dr_ack", 32'(dr_ack), 32'(e_ack[1]));
        check_val("dw_ack", 32'(dw_ack), 32'(e_ack[2]));
        check_val("op_ack", 32'(op_ack), 32'(e_ack[3]));
        check_val("pf_ack", 32'(pf_ack), 32'(e_ack[4]));
        check_val("out_addr", out_addr, e_addr);
        check_val("out_data", out_data, e_data);
        check_val("out_opcode", out_opcode, e_opcode);
        check_val("out_opaddr", out_opaddr, e_opaddr);
        check_val("out_opflag", 32'(out_opflag), 32'(e_opflag));
        check_val("out_SUC", 32'(out_SUC), 32'(e_suc));
        check_val("out_prefetch", 32'(out_prefetch), 32'(e_pf));
        check_val("out_pref_type", 32'(out_pref_type), 32'(e_pt));
        check_val("out_wstrb", 32'(out_wstrb), 32'(e_wstrb));
        check_val("out_from", 32'(out_from), 32'(e_from));
        check_val("out_size", 32'(out_size), 32'(e_size));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (!hold_mode) begin
            if (e_ack[0]) i_req = 1'b0;
            if (e_ack[1]) dr_req = 1'b0;
            if (e_ack[2]) dw_req = 1'b0;
            if (e_ack[3]) op_req = 1'b0;
            if (e_ack[4]) pf_req = 1'b0;
        end
    endtask

    task automatic wait_grant(input string tag, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!rbuf_we && cyc < 20);
        check_val({tag, "_grant"}, 32'(rbuf_we), 32'd1);
    endtask

    task automatic pulse_done();
        l2_done = 1'b1;
        step();
        l2_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int cyc;
    int exp_ord[4];

    initial begin
        edge_n = 0; hold_mode = 1'b0;
        model_reset();
        #2;
        do_reset();
        l2_ready = 1'b1;

        // single I-cache read
        i_req = 1'b1; i_addr = 32'h1000; i_size = 2'd2;
        wait_grant("t1", cyc);
        check_val("t1_latency", 32'(cyc), 32'd1);
        check_val("t1_i_ack", 32'(i_ack), 32'd1);
        check_val("t1_addr", out_addr, 32'h1000);
        check_val("t1_from", 32'(out_from), 32'd1);
        step(); step();
        check_val("t1_busy_we", 32'(rbuf_we), 32'd0);
        pulse_done();

        // round-robin with three held requesters
        do_reset();
        exp_ord = '{1, 2, 3, 1};
        hold_mode = 1'b1;
        i_req = 1'b1; dr_req = 1'b1; dw_req = 1'b1;
        dr_addr = 32'h1100; dr_size = 2'd1; dr_SUC = 1'b1;
        dw_addr = 32'h1200; dw_data = 32'h12345678; dw_wstrb = 4'h3; dw_size = 2'd1;
        for (int g = 0; g < 4; g++) begin
            wait_grant("t2", cyc);
            check_val($sformatf("t2_order%0d", g), 32'(out_from), 32'(exp_ord[g]));
            step(); step();
            pulse_done();
        end
        i_req = 1'b0; dr_req = 1'b0; dw_req = 1'b0; dr_SUC = 1'b0;
        hold_mode = 1'b0;
        step();

        // op beats Dw
        op_req = 1'b1; op_code = 32'h9; op_addr = 32'h2000;
        dw_req = 1'b1;
        wait_grant("t3op", cyc);
        check_val("t3_op_ack", 32'(op_ack), 32'd1);
        check_val("t3_opflag", 32'(out_opflag), 32'd1);
        check_val("t3_opaddr", out_opaddr, 32'h2000);
        check_val("t3_from", 32'(out_from), 32'd0);
        step(); pulse_done();
        wait_grant("t3dw", cyc);
        check_val("t3_dw_from", 32'(out_from), 32'd3);
        step(); pulse_done();

        // prefetch alone, then behind a Dr read
        pf_req = 1'b1; pf_addr = 32'h3000; pf_type = 1'b1;
        wait_grant("t4pf", cyc);
        check_val("t4_prefetch", 32'(out_prefetch), 32'd1);
        check_val("t4_pref_type", 32'(out_pref_type), 32'd1);
        check_val("t4_addr", out_addr, 32'h3000);
        step(); pulse_done();
        pf_req = 1'b1; dr_req = 1'b1;
        wait_grant("t4dr", cyc);
        check_val("t4_dr_from", 32'(out_from), 32'd2);
        step(); pulse_done();
        wait_grant("t4pf2", cyc);
        check_val("t4_pf_ack", 32'(pf_ack), 32'd1);
        step(); pulse_done();

        // l2_done during GRANT shortens BUSY to one cycle
        i_req = 1'b1; dr_req = 1'b1;
        wait_grant("t5a", cyc);
        pulse_done();
        wait_grant("t5b", cyc);
        check_val("t5_gap", 32'(cyc), 32'd2);
        step(); pulse_done();

        // reset while BUSY, held Dw request regranted afterwards
        hold_mode = 1'b1;
        dw_req = 1'b1; dw_addr = 32'h4000; dw_data = 32'hDEADBEEF; dw_wstrb = 4'hF;
        dw_size = 2'd2; dw_SUC = 1'b1;
        wait_grant("t6a", cyc);
        step(); step();
        do_reset();
        check_val("t6_rst_we", 32'(rbuf_we), 32'd0);
        check_val("t6_rst_from", 32'(out_from), 32'd0);
        wait_grant("t6b", cyc);
        check_val("t6_from", 32'(out_from), 32'd3);
        check_val("t6_data", out_data, 32'hDEADBEEF);
        check_val("t6_wstrb", 32'(out_wstrb), 32'hF);
        dw_req = 1'b0; dw_SUC = 1'b0;
        hold_mode = 1'b0;
        step(); pulse_done();

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            step();
            if (!i_req && !e_ack[0] && ($urandom % 5) == 0) begin
                i_req = 1'b1; i_addr = $urandom; i_size = 2'($urandom);
            end
            if (!dr_req && !e_ack[1] && ($urandom % 5) == 0) begin
                dr_req = 1'b1; dr_addr = $urandom; dr_size = 2'($urandom); dr_SUC = 1'($urandom);
            end
            if (!dw_req && !e_ack[2] && ($urandom % 5) == 0) begin
                dw_req = 1'b1; dw_addr = $urandom; dw_data = $urandom;
                dw_wstrb = 4'($urandom); dw_size = 2'($urandom); dw_SUC = 1'($urandom);
            end
            if (!op_req && !e_ack[3] && ($urandom % 12) == 0) begin
                op_req = 1'b1; op_code = $urandom; op_addr = $urandom;
            end
            if (!pf_req && !e_ack[4] && ($urandom % 6) == 0) begin
                pf_req = 1'b1; pf_addr = $urandom; pf_type = 1'($urandom);
            end
            l2_ready = (($urandom % 8) != 0);
            l2_done  = (($urandom % 4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
